// File: rtl/vit_qpsk_llr_demap_pkg.sv
// Shared types and helpers for the QPSK soft demapper in front of vit_dec.
package vit_qpsk_llr_demap_pkg;

  localparam int cDAT_W = 16;

  typedef struct packed {
    logic signed [cDAT_W-1:0] re;
    logic signed [cDAT_W-1:0] im;
  } cmplx_dat_t;

  typedef enum logic [0:0] {
    cIDLE  = 1'b0,
    cFRAME = 1'b1
  } state_t;

  // Symmetric clip to +-smax, so that -smax-1 never reaches the LLR slice.
  function automatic logic signed [31:0] sat_sym(input logic signed [31:0] x,
                                                 input logic signed [31:0] smax);
    if (x > smax)
      return smax;
    else if (x < -smax)
      return -smax;
    else
      return x;
  endfunction

endpackage

// File: rtl/vit_llr_sat_quant.sv
// One demapper component: registered saturate/hard bit/clip flag, then registered LLR.
module vit_llr_sat_quant
  import vit_qpsk_llr_demap_pkg::*;
#(
  parameter int pDAT_W    = 16,
  parameter int pREF_LOG2 = 10,
  parameter int pLLR_W    = 4
) (
  input  logic                     iclk,
  input  logic                     ireset,
  input  logic                     iclkena,
  input  logic signed [pDAT_W-1:0] idat,
  input  logic                     ierase,
  output logic                     ohard,
  output logic                     osat,
  output logic [pLLR_W-1:0]        oLLR
);

  localparam int cS_W = pREF_LOG2 + 2;
  localparam logic signed [31:0] cSMAX = 32'((1 << (pREF_LOG2 + 1)) - 1);

  logic signed [31:0] datExt;
  logic signed [31:0] satVal;
  logic [pLLR_W-1:0]  s_d, s_q;
  logic [pLLR_W-1:0]  llr_d, llr_q;
  logic               sat_d, sat_q;
  logic               hard1_q, hard2_q, erase_q;

  // Only the top pLLR_W bits of the clipped sample feed the LLR, so only those are kept.
  always_comb begin
    datExt = 32'(idat);
    satVal = sat_sym(datExt, cSMAX);
    sat_d  = (satVal != datExt) && !ierase;
    s_d    = satVal[cS_W-1 -: pLLR_W];
    llr_d  = erase_q ? '0 : s_q + pLLR_W'(s_q[pLLR_W-1]);
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      s_q     <= '0;
      sat_q   <= 1'b0;
      hard1_q <= 1'b0;
      erase_q <= 1'b0;
      llr_q   <= '0;
      hard2_q <= 1'b0;
    end else if (iclkena) begin
      s_q     <= s_d;
      sat_q   <= sat_d;
      hard1_q <= !idat[pDAT_W-1];
      erase_q <= ierase;
      llr_q   <= llr_d;
      hard2_q <= hard1_q;
    end
  end

  assign ohard = hard2_q;
  assign osat  = sat_q;
  assign oLLR  = llr_q;

endmodule

// File: rtl/vit_qpsk_llr_demap.sv
// QPSK soft demapper with framing check and per-frame saturation count.
// Optional erasure input enabled by defining VIT_QPSK_LLR_DEMAP_ERASURE_EN.
module vit_qpsk_llr_demap
  import vit_qpsk_llr_demap_pkg::*;
#(
  parameter int pDAT_W    = 16,
  parameter int pREF_LOG2 = 10,
  parameter int pLLR_W    = 4
) (
  input  logic                          iclk,
  input  logic                          ireset,
  input  logic                          iclkena,
  input  logic                          isop,
  input  logic                          ieop,
  input  logic                          ival,
`ifdef VIT_QPSK_LLR_DEMAP_ERASURE_EN
  input  logic                          ierase,
`endif
  input  logic signed [pDAT_W-1:0]      idat_re,
  input  logic signed [pDAT_W-1:0]      idat_im,
  output logic                          osop,
  output logic                          oeop,
  output logic                          oval,
  output logic [1:0]                    odat,
  output logic [1:0][pLLR_W-1:0]        oLLR,
  output logic [15:0]                   osatcnt,
  output logic                          oframe_err
);

  cmplx_dat_t sampleIn;
  state_t     state_d, state_q;
  logic       pass, sopOut, eopOut, errOut, eraseIn;
  logic       val1_q, sop1_q, eop1_q, err1_q;
  logic       val2_q, sop2_q, eop2_q, err2_q;
  logic       satRe, satIm;
  logic [15:0] accBase, acc_d, acc_q, satcnt_q;
  logic [16:0] accSum;

  assign sampleIn = '{re: idat_re, im: idat_im};

`ifdef VIT_QPSK_LLR_DEMAP_ERASURE_EN
  assign eraseIn = ierase && ival;
`else
  assign eraseIn = 1'b0;
`endif

  // A sop inside a frame restarts it; a sop with eop in either state is a one-sample frame.
  always_comb begin
    state_d = state_q;
    pass    = 1'b0;
    sopOut  = 1'b0;
    eopOut  = 1'b0;
    errOut  = 1'b0;
    if (ival) begin
      case (state_q)
        cIDLE: begin
          if (isop) begin
            pass   = 1'b1;
            sopOut = 1'b1;
            eopOut = ieop;
            if (!ieop) state_d = cFRAME;
          end else begin
            errOut = 1'b1;
          end
        end
        cFRAME: begin
          pass   = 1'b1;
          sopOut = isop;
          errOut = isop;
          eopOut = ieop;
          if (ieop) state_d = cIDLE;
        end
        default: state_d = cIDLE;
      endcase
    end
  end

  always_comb begin
    accBase = sop1_q ? 16'd0 : acc_q;
    accSum  = {1'b0, accBase} + 17'(satRe) + 17'(satIm);
    acc_d   = accSum[16] ? 16'hFFFF : accSum[15:0];
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q  <= cIDLE;
      val1_q   <= 1'b0;
      sop1_q   <= 1'b0;
      eop1_q   <= 1'b0;
      err1_q   <= 1'b0;
      val2_q   <= 1'b0;
      sop2_q   <= 1'b0;
      eop2_q   <= 1'b0;
      err2_q   <= 1'b0;
      acc_q    <= '0;
      satcnt_q <= '0;
    end else if (iclkena) begin
      state_q <= state_d;
      val1_q  <= pass;
      sop1_q  <= pass && sopOut;
      eop1_q  <= pass && eopOut;
      err1_q  <= errOut;
      val2_q  <= val1_q;
      sop2_q  <= sop1_q;
      eop2_q  <= eop1_q;
      err2_q  <= err1_q;
      if (val1_q) acc_q <= acc_d;
      if (val1_q && eop1_q) satcnt_q <= acc_d;
    end
  end

  vit_llr_sat_quant #(.pDAT_W(pDAT_W), .pREF_LOG2(pREF_LOG2), .pLLR_W(pLLR_W)) uQuantRe (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .idat    (sampleIn.re),
    .ierase  (eraseIn),
    .ohard   (odat[1]),
    .osat    (satRe),
    .oLLR    (oLLR[1])
  );

  vit_llr_sat_quant #(.pDAT_W(pDAT_W), .pREF_LOG2(pREF_LOG2), .pLLR_W(pLLR_W)) uQuantIm (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .idat    (sampleIn.im),
    .ierase  (eraseIn),
    .ohard   (odat[0]),
    .osat    (satIm),
    .oLLR    (oLLR[0])
  );

  assign osop       = sop2_q;
  assign oeop       = eop2_q;
  assign oval       = val2_q;
  assign osatcnt    = satcnt_q;
  assign oframe_err = err2_q;

endmodule

// File: tb/tb_vit_qpsk_llr_demap.sv
// Directed self-checking bench for vit_qpsk_llr_demap (default parameters).
module tb_vit_qpsk_llr_demap;

  logic              iclk = 1'b0;
  logic              ireset, iclkena, isop, ieop, ival;
  logic signed [15:0] idat_re, idat_im;
  logic              osop, oeop, oval, oframe_err;
  logic [1:0]        odat;
  logic [1:0][3:0]   oLLR;
  logic [15:0]       osatcnt;
`ifdef VIT_QPSK_LLR_DEMAP_ERASURE_EN
  logic              ierase = 1'b0;
`endif

  int compareCnt  = 0;
  int mismatchCnt = 0;

  vit_qpsk_llr_demap dut (
    .iclk       (iclk),
    .ireset     (ireset),
    .iclkena    (iclkena),
    .isop       (isop),
    .ieop       (ieop),
    .ival       (ival),
`ifdef VIT_QPSK_LLR_DEMAP_ERASURE_EN
    .ierase     (ierase),
`endif
    .idat_re    (idat_re),
    .idat_im    (idat_im),
    .osop       (osop),
    .oeop       (oeop),
    .oval       (oval),
    .odat       (odat),
    .oLLR       (oLLR),
    .osatcnt    (osatcnt),
    .oframe_err (oframe_err)
  );

  always #5 iclk = ~iclk;

  task automatic checkOutput(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
    compareCnt++;
    if (got !== exp) begin
      mismatchCnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic applyStimulus(input logic ena, input logic val, input logic sop,
                               input logic eop, input int re, input int im);
    iclkena = ena;
    ival    = val;
    isop    = sop;
    ieop    = eop;
    idat_re = 16'(re);
    idat_im = 16'(im);
    @(posedge iclk);
    #1;
  endtask

  function automatic int llrOf(input int x);
    int s;
    s = (x > 2047) ? 2047 : (x < -2047) ? -2047 : x;
    return (s >>> 8) + ((s < 0) ? 1 : 0);
  endfunction

  int expRe[100];
  int tries, reVal, cnt;
  logic ena;

  initial begin
    ireset = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rst_oval", oval, 0);
    checkOutput("rst_odat", odat, 0);
    checkOutput("rst_llr", oLLR, 0);
    checkOutput("rst_satcnt", osatcnt, 0);
    checkOutput("rst_err", oframe_err, 0);
    ireset = 1'b0;

    $display("[TB] test 1: one-sample frame");
    applyStimulus(1, 1, 1, 1, 1024, -1024);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t1_oval", oval, 1);
    checkOutput("t1_sop_eop", {osop, oeop}, 3);
    checkOutput("t1_odat", odat, 2'b10);
    checkOutput("t1_llr_re", $signed(oLLR[1]), 4);
    checkOutput("t1_llr_im", $signed(oLLR[0]), -3);
    checkOutput("t1_satcnt", osatcnt, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t1_oval_after", oval, 0);

    $display("[TB] test 2: 8-sample frame with clipping");
    for (int i = 0; i <= 8; i++) begin
      if (i < 8)
        applyStimulus(1, 1, i == 0, i == 7, (i == 1 || i == 4) ? 3000 : 100,
                      (i == 4) ? -5000 : 200);
      else
        applyStimulus(1, 0, 0, 0, 0, 0);
      if (i >= 1) begin
        checkOutput($sformatf("t2_oval_%0d", i - 1), oval, 1);
        checkOutput($sformatf("t2_llr_re_%0d", i - 1), $signed(oLLR[1]),
                    (i - 1 == 1 || i - 1 == 4) ? 7 : 0);
        checkOutput($sformatf("t2_llr_im_%0d", i - 1), $signed(oLLR[0]),
                    (i - 1 == 4) ? -7 : 0);
        checkOutput($sformatf("t2_eop_%0d", i - 1), oeop, (i - 1 == 7) ? 1 : 0);
      end
    end
    checkOutput("t2_satcnt", osatcnt, 3);

    $display("[TB] test 3: framing violations");
    applyStimulus(1, 1, 0, 0, 500, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t3_drop_oval", oval, 0);
    checkOutput("t3_drop_err", oframe_err, 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t3_err_pulse", oframe_err, 0);
    applyStimulus(1, 1, 1, 0, 3000, 0);
    applyStimulus(1, 1, 0, 0, 100, 0);
    applyStimulus(1, 1, 1, 0, 100, 0);
    checkOutput("t3_b_sop", osop, 0);
    checkOutput("t3_b_err", oframe_err, 0);
    applyStimulus(1, 1, 0, 1, 100, -5000);
    checkOutput("t3_restart_sop", osop, 1);
    checkOutput("t3_restart_err", oframe_err, 1);
    checkOutput("t3_restart_val", oval, 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t3_eop", oeop, 1);
    checkOutput("t3_llr_im", $signed(oLLR[0]), -7);
    checkOutput("t3_satcnt", osatcnt, 1);

    $display("[TB] test 5: reset mid-frame");
    for (int i = 0; i < 50; i++)
      applyStimulus(1, 1, i == 0, 0, 3000, 0);
    ireset = 1'b1;
    applyStimulus(1, 1, 0, 0, 3000, 0);
    ireset = 1'b0;
    checkOutput("t5_oval", oval, 0);
    checkOutput("t5_llr", oLLR, 0);
    checkOutput("t5_satcnt", osatcnt, 0);
    checkOutput("t5_odat", odat, 0);
    cnt = 0;
    for (int i = 51; i < 100; i++) begin
      applyStimulus(1, 1, 0, i == 99, 3000, 0);
      if (oval || oeop) cnt++;
    end
    applyStimulus(1, 0, 0, 0, 0, 0);
    if (oval || oeop) cnt++;
    checkOutput("t5_no_output", cnt, 0);
    applyStimulus(1, 1, 1, 1, -3000, 2047);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t5_fresh_oval", oval, 1);
    checkOutput("t5_fresh_odat", odat, 2'b01);
    checkOutput("t5_fresh_llr_re", $signed(oLLR[1]), -7);
    checkOutput("t5_fresh_llr_im", $signed(oLLR[0]), 7);
    checkOutput("t5_fresh_satcnt", osatcnt, 1);

    $display("[TB] test 4: random clock enable");
    for (int i = 0; i < 100; i++) begin
      reVal    = i * 40 - 2000;
      expRe[i] = llrOf(reVal);
    end
    for (int i = 0; i < 100; i++) begin
      reVal = i * 40 - 2000;
      tries = 0;
      do begin
        ena = (tries >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        applyStimulus(ena, 1, i == 0, i == 99, reVal, 0);
        tries++;
        if (ena && i >= 1) begin
          checkOutput($sformatf("t4_oval_%0d", i - 1), oval, 1);
          checkOutput($sformatf("t4_llr_%0d", i - 1), $signed(oLLR[1]), expRe[i-1]);
          checkOutput($sformatf("t4_hard_%0d", i - 1), odat[1], (i - 1 >= 50) ? 1 : 0);
        end else if (!ena && i >= 2) begin
          checkOutput($sformatf("t4_hold_%0d", i - 2), $signed(oLLR[1]), expRe[i-2]);
        end
      end while (!ena);
    end
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t4_last_llr", $signed(oLLR[1]), expRe[99]);
    checkOutput("t4_last_eop", oeop, 1);
    checkOutput("t4_satcnt", osatcnt, 0);

`ifdef VIT_QPSK_LLR_DEMAP_ERASURE_EN
    $display("[TB] test 6: erasure");
    applyStimulus(1, 1, 1, 0, 3000, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    ierase = 1'b1;
    applyStimulus(1, 1, 0, 0, 2047, -3000);
    ierase = 1'b0;
    applyStimulus(1, 1, 0, 1, 0, 0);
    checkOutput("t6_llr", oLLR, 0);
    checkOutput("t6_odat", odat, 2'b10);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t6_satcnt", osatcnt, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
    $finish;
  end

endmodule
